// File: rtl/io_fifo_control_pkg.sv
// io_fifo_control_pkg: shared widths, MMIO address map and status bit positions
package io_fifo_control_pkg;
   localparam int XLEN         = 32;
   localparam int IO_MAP_WIDTH = 8;
   localparam int BAUD_RATE    = 115_200;

   localparam logic [IO_MAP_WIDTH-1:0] ADR_STATUS  = 8'h00;
   localparam logic [IO_MAP_WIDTH-1:0] ADR_RX_DATA = 8'h01;
   localparam logic [IO_MAP_WIDTH-1:0] ADR_TX_DATA = 8'h02;
   localparam logic [IO_MAP_WIDTH-1:0] ADR_IRQ_EN  = 8'h03;
   localparam logic [IO_MAP_WIDTH-1:0] ADR_CYCLE   = 8'h04;
   localparam logic [IO_MAP_WIDTH-1:0] ADR_INSTRET = 8'h05;
   localparam logic [IO_MAP_WIDTH-1:0] ADR_CNT_RST = 8'h06;
   localparam logic [IO_MAP_WIDTH-1:0] ADR_OVF_CLR = 8'h07;

   localparam int ST_TX_NOT_FULL  = 0;
   localparam int ST_RX_NOT_EMPTY = 1;
   localparam int ST_RX_OVF       = 2;
   localparam int ST_TX_OVF       = 3;
   localparam int ST_RX_CNT       = 8;
   localparam int ST_TX_CNT       = 16;
endpackage

// File: rtl/io_sync_fifo.sv
// io_sync_fifo: single-clock FIFO; push into a full FIFO succeeds only alongside a pop
module io_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CWL = AW + 1
) (
   input  logic             clk,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign empty_o = cnt_q == '0;
   assign full_o  = cnt_q == CWL'(DEPTH);
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rd_q];
   assign do_pop  = pop_i & !empty_o;
   assign do_push = push_i & (!full_o | do_pop);

   // pointer and occupancy next state; power-of-two depth lets pointers wrap naturally
   always_comb begin
      wr_d  = do_push ? wr_q + AW'(1) : wr_q;
      rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q + CWL'(do_push) - CWL'(do_pop);
   end

   // pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // storage array, contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end
endmodule

// File: rtl/uart.sv
// uart: 8N1 transmitter and receiver with ready/valid byte interfaces
module uart #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_in_ready,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready,
   input  logic       serial_in,
   output logic       serial_out
);
   localparam int CPS = CLOCK_FREQ / BAUD_RATE;
   localparam int CW  = $clog2(CPS);

   logic [9:0]    tx_sh_q, rx_sh_q;
   logic [3:0]    tx_bits_q, rx_bits_q;
   logic [CW-1:0] tx_clk_q, rx_clk_q;
   logic [1:0]    rx_sync_q;
   logic          rx_valid_q, tx_busy, rx_line;

   assign tx_busy        = tx_bits_q != 4'd0;
   assign data_in_ready  = !tx_busy;
   assign serial_out     = tx_busy ? tx_sh_q[0] : 1'b1;
   assign rx_line        = rx_sync_q[1];
   assign data_out       = rx_sh_q[8:1];
   assign data_out_valid = rx_valid_q;

   // transmit shifter: start bit, 8 data bits LSB first, stop bit
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_sh_q   <= '1;
         tx_bits_q <= '0;
         tx_clk_q  <= '0;
      end else if (data_in_valid && !tx_busy) begin
         tx_sh_q   <= {1'b1, data_in, 1'b0};
         tx_bits_q <= 4'd10;
         tx_clk_q  <= '0;
      end else if (tx_busy) begin
         if (tx_clk_q == CW'(CPS - 1)) begin
            tx_clk_q  <= '0;
            tx_sh_q   <= {1'b1, tx_sh_q[9:1]};
            tx_bits_q <= tx_bits_q - 4'd1;
         end else begin
            tx_clk_q <= tx_clk_q + CW'(1);
         end
      end
   end

   // receiver: synchronise the line, sample each bit mid-symbol, flag a byte after the stop bit
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_sync_q  <= 2'b11;
         rx_sh_q    <= '0;
         rx_bits_q  <= '0;
         rx_clk_q   <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_sync_q <= {rx_sync_q[0], serial_in};
         if (rx_bits_q == 4'd0) begin
            if (!rx_line) begin
               rx_bits_q <= 4'd10;
               rx_clk_q  <= CW'(CPS / 2);
            end
         end else if (rx_clk_q == '0) begin
            rx_sh_q   <= {rx_line, rx_sh_q[9:1]};
            rx_bits_q <= rx_bits_q - 4'd1;
            rx_clk_q  <= CW'(CPS - 1);
         end else begin
            rx_clk_q <= rx_clk_q - CW'(1);
         end
         if (rx_bits_q == 4'd1 && rx_clk_q == '0) rx_valid_q <= 1'b1;
         else if (data_out_ready) rx_valid_q <= 1'b0;
      end
   end
endmodule

// File: rtl/io_fifo_control.sv
// io_fifo_control: MMIO front end for a UART with RX/TX FIFOs, status, irq; counters under IO_PERF_CNT_EN
module io_fifo_control
   import io_fifo_control_pkg::*;
#(
   parameter int CPU_CLOCK_FREQ = 50_000_000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                    clk,
   input  logic                    cpu_rst,
   input  logic                    io_en,
   input  logic [3:0]              wea,
   input  logic [IO_MAP_WIDTH-1:0] adr,
   input  logic [XLEN-1:0]         din_io,
   input  logic                    instr_stop,
   input  logic                    uart_serial_in,
   output logic [XLEN-1:0]         dout_io,
   output logic                    uart_serial_out,
   output logic                    irq
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic            acc, wr, rd, rx_pop, rx_push, tx_push, tx_pop, tx_ready, ovf_clr;
   logic            rx_full, rx_empty, tx_full, tx_empty;
   logic [7:0]      rx_byte, rx_head, tx_head;
   logic [CW-1:0]   rx_cnt, tx_cnt;
   logic            rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d, irq_q, irq_d;
   logic [1:0]      irq_en_q, irq_en_d;
   logic [XLEN-1:0] dout_q, dout_d, status, rdata, cyc_rd, ins_rd;
   logic            unused_in;

   assign acc       = io_en & !cpu_rst;
   assign wr        = acc & (|wea);
   assign rd        = acc & !(|wea);
   assign rx_pop    = rd & (adr == ADR_RX_DATA);
   assign tx_push   = wr & (adr == ADR_TX_DATA);
   assign ovf_clr   = wr & (adr == ADR_OVF_CLR);
   assign tx_pop    = !tx_empty & tx_ready;
   assign dout_io   = dout_q;
   assign irq       = irq_q;
   assign unused_in = ^din_io[XLEN-1:8];

   io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst_i(cpu_rst), .push_i(rx_push), .pop_i(rx_pop), .din_i(rx_byte),
      .dout_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt)
   );

   io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst_i(cpu_rst), .push_i(tx_push), .pop_i(tx_pop), .din_i(din_io[7:0]),
      .dout_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt)
   );

   uart #(.CLOCK_FREQ(CPU_CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_uart (
      .clk(clk), .reset(cpu_rst), .data_in(tx_head), .data_in_valid(!tx_empty),
      .data_in_ready(tx_ready), .data_out(rx_byte), .data_out_valid(rx_push),
      .data_out_ready(1'b1), .serial_in(uart_serial_in), .serial_out(uart_serial_out)
   );

`ifdef IO_PERF_CNT_EN
   logic            cnt_clr;
   logic [XLEN-1:0] cyc_q, cyc_d, ins_q, ins_d;

   assign cnt_clr = wr & (adr == ADR_CNT_RST);
   assign cyc_rd  = cyc_q;
   assign ins_rd  = ins_q;

   // free-running cycle and retired-instruction counters, wrapping at 2^32
   always_comb begin
      cyc_d = cnt_clr ? '0 : cyc_q + XLEN'(1);
      ins_d = cnt_clr ? '0 : ins_q + XLEN'(!instr_stop);
   end

   // counter registers
   always_ff @(posedge clk) begin
      if (cpu_rst) begin
         cyc_q <= '0;
         ins_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         ins_q <= ins_d;
      end
   end
`else
   logic unused_perf;

   assign unused_perf = instr_stop;
   assign cyc_rd      = '0;
   assign ins_rd      = '0;
`endif

   // sticky overflows (set beats clear), irq enable, status word and read mux
   always_comb begin
      rx_ovf_d = (rx_push & rx_full & !rx_pop) | (rx_ovf_q & !ovf_clr);
      tx_ovf_d = (tx_push & tx_full & !tx_pop) | (tx_ovf_q & !ovf_clr);
      irq_en_d = (wr && adr == ADR_IRQ_EN) ? din_io[1:0] : irq_en_q;
      irq_d    = (irq_en_q[0] & !rx_empty) | (irq_en_q[1] & tx_empty);
      status                   = '0;
      status[ST_TX_NOT_FULL]   = !tx_full;
      status[ST_RX_NOT_EMPTY]  = !rx_empty;
      status[ST_RX_OVF]        = rx_ovf_q;
      status[ST_TX_OVF]        = tx_ovf_q;
      status[ST_RX_CNT +: 8]   = 8'(rx_cnt);
      status[ST_TX_CNT +: 8]   = 8'(tx_cnt);
      case (adr)
         ADR_STATUS:  rdata = status;
         ADR_RX_DATA: rdata = rx_empty ? '0 : XLEN'(rx_head);
         ADR_IRQ_EN:  rdata = XLEN'(irq_en_q);
         ADR_CYCLE:   rdata = cyc_rd;
         ADR_INSTRET: rdata = ins_rd;
         default:     rdata = '0;
      endcase
      dout_d = rd ? rdata : '0;
   end

   // control/status registers and registered outputs
   always_ff @(posedge clk) begin
      if (cpu_rst) begin
         rx_ovf_q <= 1'b0;
         tx_ovf_q <= 1'b0;
         irq_en_q <= '0;
         irq_q    <= 1'b0;
         dout_q   <= '0;
      end else begin
         rx_ovf_q <= rx_ovf_d;
         tx_ovf_q <= tx_ovf_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
         dout_q   <= dout_d;
      end
   end
endmodule

// File: tb/tb_io_fifo_control.sv
// tb_io_fifo_control: directed self-checking bench for io_fifo_control with serial loopback
module tb_io_fifo_control;
   import io_fifo_control_pkg::*;

   logic                    clk = 1'b0;
   logic                    cpu_rst, io_en, instr_stop, loop;
   logic [3:0]              wea;
   logic [IO_MAP_WIDTH-1:0] adr;
   logic [XLEN-1:0]         din_io, dout_io, v;
   logic                    uart_serial_in, uart_serial_out, irq;
   int                      n_cmp = 0, n_err = 0;

   assign uart_serial_in = loop ? uart_serial_out : 1'b1;

   io_fifo_control #(.CPU_CLOCK_FREQ(1_152_000), .FIFO_DEPTH(8)) dut (
      .clk(clk), .cpu_rst(cpu_rst), .io_en(io_en), .wea(wea), .adr(adr), .din_io(din_io),
      .instr_stop(instr_stop), .uart_serial_in(uart_serial_in), .dout_io(dout_io),
      .uart_serial_out(uart_serial_out), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic acc(input logic w, input logic [IO_MAP_WIDTH-1:0] a, input logic [XLEN-1:0] d);
      io_en  = 1'b1;
      wea    = w ? 4'hF : 4'h0;
      adr    = a;
      din_io = d;
      tick(1);
      io_en  = 1'b0;
      wea    = 4'h0;
   endtask

   task automatic rd(input logic [IO_MAP_WIDTH-1:0] a, output logic [XLEN-1:0] d);
      acc(1'b0, a, '0);
      d = dout_io;
   endtask

   task automatic wait_status(input string tag, input logic [31:0] exp, input int budget);
      logic [31:0] s;
      int n = 0;
      do begin
         rd(ADR_STATUS, s);
         n++;
      end while (s !== exp && n < budget);
      check(tag, s, exp);
   endtask

   initial begin
      cpu_rst = 1'b1; io_en = 1'b0; wea = '0; adr = '0; din_io = '0; instr_stop = 1'b1; loop = 1'b0;
      tick(3);
      check("rst_dout", dout_io, 0);
      check("rst_irq", 32'(irq), 0);
      check("rst_txline", 32'(uart_serial_out), 1);
      cpu_rst = 1'b0;
      rd(ADR_STATUS, v);   check("status_after_rst", v, 32'h1);
      rd(ADR_IRQ_EN, v);   check("irq_en_after_rst", v, 0);
      rd(ADR_RX_DATA, v);  check("rx_empty_read", v, 0);
      rd(ADR_STATUS, v);   check("rx_cnt_unchanged", v, 32'h1);
      rd(8'h08, v);        check("unmapped_read", v, 0);
      rd(ADR_STATUS, v);
      acc(1'b1, ADR_IRQ_EN, 32'h2);
      check("dout_after_write", dout_io, 0);
      check("irq_tx_lag", 32'(irq), 0);
      tick(1);             check("irq_tx_empty", 32'(irq), 1);
      rd(ADR_IRQ_EN, v);   check("irq_en_read", v, 32'h2);
      acc(1'b1, ADR_IRQ_EN, 32'h0);
      check("irq_fall_lag", 32'(irq), 1);
      tick(1);             check("irq_off", 32'(irq), 0);
      loop = 1'b1;
      acc(1'b1, ADR_TX_DATA, 32'h41);
      acc(1'b1, ADR_TX_DATA, 32'h42);
      acc(1'b1, ADR_TX_DATA, 32'h43);
      wait_status("loop_rx3", 32'h0000_0303, 800);
      rd(ADR_RX_DATA, v);  check("rx_byte0", v, 32'h41);
      rd(ADR_RX_DATA, v);  check("rx_byte1", v, 32'h42);
      rd(ADR_RX_DATA, v);  check("rx_byte2", v, 32'h43);
      rd(ADR_STATUS, v);   check("rx_drained", v, 32'h1);
      acc(1'b1, ADR_IRQ_EN, 32'h1);
      acc(1'b1, ADR_TX_DATA, 32'h5A);
      for (int n = 0; n < 400 && !dut.rx_push; n++) tick(1);
      check("rx_push_seen", 32'(dut.rx_push), 1);
      tick(1);             check("irq_rx_lag", 32'(irq), 0);
      tick(1);             check("irq_rx_rise", 32'(irq), 1);
      rd(ADR_RX_DATA, v);  check("rx_irq_byte", v, 32'h5A);
      check("irq_pop_lag", 32'(irq), 1);
      tick(1);             check("irq_rx_fall", 32'(irq), 0);
      acc(1'b1, ADR_IRQ_EN, 32'h0);
      loop = 1'b0;
      acc(1'b1, ADR_TX_DATA, 32'hAA);
      tick(3);
      for (int i = 0; i < 9; i++) acc(1'b1, ADR_TX_DATA, 32'(i));
      rd(ADR_STATUS, v);   check("tx_overflow", v, 32'h0008_0008);
      acc(1'b1, ADR_OVF_CLR, 32'h0);
      rd(ADR_STATUS, v);   check("tx_ovf_cleared", v, 32'h0008_0000);
      wait_status("tx_drain", 32'h1, 2000);
`ifdef IO_PERF_CNT_EN
      acc(1'b1, ADR_CNT_RST, 32'h0);
      tick(10);
      instr_stop = 1'b0;
      tick(5);
      instr_stop = 1'b1;
      rd(ADR_INSTRET, v);  check("instret_5", v, 32'd5);
      rd(ADR_CYCLE, v);    check("cycle_ge15", 32'(v >= 32'd15), 1);
      dut.cyc_q = '1;
      dut.ins_q = '1;
      instr_stop = 1'b0;
      tick(1);
      instr_stop = 1'b1;
      rd(ADR_CYCLE, v);    check("cycle_wrap", v, 0);
      rd(ADR_INSTRET, v);  check("instret_wrap", v, 0);
`else
      acc(1'b1, ADR_CNT_RST, 32'h0);
      tick(5);
      rd(ADR_CYCLE, v);    check("cycle_absent", v, 0);
      rd(ADR_INSTRET, v);  check("instret_absent", v, 0);
`endif
      acc(1'b1, ADR_TX_DATA, 32'h11);
      acc(1'b1, ADR_TX_DATA, 32'h22);
      acc(1'b1, ADR_TX_DATA, 32'h33);
      tick(20);
      cpu_rst = 1'b1; io_en = 1'b1; wea = 4'hF; adr = ADR_IRQ_EN; din_io = 32'h3;
      tick(2);
      check("midrst_dout", dout_io, 0);
      check("midrst_line", 32'(uart_serial_out), 1);
      cpu_rst = 1'b0; io_en = 1'b0; wea = '0;
      rd(ADR_STATUS, v);   check("midrst_status", v, 32'h1);
      rd(ADR_IRQ_EN, v);   check("rst_access_ignored", v, 0);
      tick(300);
      check("line_idle_after_rst", 32'(uart_serial_out), 1);
      rd(ADR_STATUS, v);   check("status_still_empty", v, 32'h1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/io_fifo_control.md
IO_FIFO_CONTROL -- requirements
Module: io_fifo_control

Interface
REQ-001 Parameter CPU_CLOCK_FREQ, default 50_000_000: core clock in Hz, passed to the uart instance.
REQ-002 Parameter FIFO_DEPTH, default 8: entries per RX and TX FIFO; power of two, 2..128.
REQ-003 clk  input  1  core clock; single clock domain, all state updates on rising edge.
REQ-004 cpu_rst  input  1  reset is synchronous and active-high.
REQ-005 io_en  input  1  MMIO access strobe, one cycle per access.
REQ-006 wea  input  4  byte write enables; nonzero means write, zero means read.
REQ-007 adr  input  IO_MAP_WIDTH  word address within the IO region.
REQ-008 din_io  input  XLEN  write data.
REQ-009 instr_stop  input  1  high means no instruction retired this cycle.
REQ-010 uart_serial_in  input  1  UART RX line.
REQ-011 dout_io  output  XLEN  registered read data.
REQ-012 uart_serial_out  output  1  UART TX line.
REQ-013 irq  output  1  registered level interrupt.

Function
REQ-014 The block SHALL decode these addresses: 0x00 status (R), 0x01 RX data (R, pop), 0x02 TX data (W, push), 0x03 irq_en (RW, bits[1:0]), 0x04 cycle count (R), 0x05 instret count (R), 0x06 counter reset (W), 0x07 overflow clear (W).
REQ-015 Status SHALL read as: bit0 !tx_full, bit1 !rx_empty, bit2 rx_ovf, bit3 tx_ovf, [15:8] rx_count, [23:16] tx_count, all other bits 0.
REQ-016 dout_io SHALL be valid on the cycle after a read access; it SHALL be 0 after writes, idle cycles and reads of unmapped addresses.
REQ-017 A read of 0x01 with the RX FIFO non-empty SHALL return {24'b0, head byte} and pop it on the same edge; with RX empty it SHALL return 0 with no pointer change.
REQ-018 A write to 0x02 SHALL push din_io[7:0]; if TX is full, the byte SHALL be dropped and tx_ovf SET.
REQ-019 The TX drain SHALL present the TX head byte with data_in_valid to the uart while TX is non-empty, and SHALL pop it on the cycle data_in_valid and data_in_ready are both high.
REQ-020 uart data_out_ready SHALL be tied 1; each received byte SHALL be pushed to RX, or dropped with rx_ovf SET if RX is full and no pop occurs that cycle.
REQ-021 A simultaneous push and pop on a full FIFO SHALL succeed; the count is unchanged and there is no overflow. A simultaneous push and pop on an empty FIFO SHALL perform the push only.
REQ-022 The rx_ovf and tx_ovf bits SHALL be sticky until a write to 0x07 clears both; if set and clear occur in the same cycle, the set wins.
REQ-023 The cycle counter SHALL increment every cycle, and the instret counter SHALL increment when instr_stop is 0; both SHALL be 32-bit and wrap from 0xFFFFFFFF to 0.
REQ-024 A write to 0x06 SHALL zero both counters; they SHALL read 0 on the following cycle and resume counting after that.
REQ-025 irq SHALL update one cycle after its inputs, as (irq_en[0] & !rx_empty) | (irq_en[1] & tx_empty).

Reset
REQ-026 While cpu_rst is high, the following SHALL be held:
- dout_io = 0, irq = 0, irq_en = 0;
- both FIFOs empty, both overflow bits 0, both counters 0;
- uart_serial_out idle high.
REQ-027 Reset asserted mid-transfer SHALL discard all FIFO contents; any byte in flight inside the uart is abandoned.
REQ-028 An access in the same cycle as cpu_rst SHALL be ignored.

Configuration
REQ-029 With macro IO_PERF_CNT_EN defined, the counters SHALL be present as specified.
REQ-030 Without IO_PERF_CNT_EN, the counters SHALL NOT be instantiated, reads of 0x04 and 0x05 SHALL return 0, and writes to 0x06 SHALL be ignored.

Structure
REQ-031 The address constants (0x00-0x07), the status bit positions and IO_MAP_WIDTH/XLEN SHALL reside in the shared defines file.
REQ-032 One sub-module io_sync_fifo (parameters WIDTH=8, DEPTH) SHALL be instantiated twice, for RX and TX; it exposes full, empty and count outputs.
REQ-033 The existing uart module SHALL be instantiated unchanged.

Verification
REQ-034 Write 0x41, 0x42, 0x43 to 0x02 with serial loopback → all three bytes are received in order; 0x01 reads 0x41, 0x42, 0x43; status bit1 then reads 0.
REQ-035 Write FIFO_DEPTH+1 bytes back-to-back while the uart is busy → last byte dropped, status bit3 = 1 and bit0 = 0; write to 0x07 → bit3 reads 0.
REQ-036 Read 0x01 with RX empty → dout_io = 0 and rx_count stays 0.
REQ-037 Hold instr_stop=1 for 10 cycles then 0 for 5 cycles after a 0x06 write → instret = 5 and cycle ≥ 15; preset the counters to 0xFFFFFFFF and step one cycle → both read 0.
REQ-038 Set irq_en = 0b01 and inject one RX byte → irq rises one cycle after the push and falls one cycle after the pop.
REQ-039 Assert cpu_rst mid-transmission with 3 bytes queued → status reads 0x00000001 after reset and uart_serial_out is high.
